ysyx_22040365_ifu: RTL

//   Instruction fetch unit: owns the PC and fetches from instruction memory over a req/rsp handshake.

---
 rtl/ysyx_22040365_ifu_pkg.sv | 14 +
 rtl/ysyx_22040365_pc_reg.sv | 24 ++
 rtl/ysyx_22040365_ifu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared IFU definitions: FSM state encodings, instruction width, boot PC and NOP encoding.
package ysyx_22040365_ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_e;

    localparam int          INST_W       = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22040365_pc_reg.sv
// Fetch PC register: boot value on reset, redirect load has priority over the +4 advance.
module ysyx_22040365_pc_reg #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (advance) begin
            pc <= pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding imem request, output buffer towards decode.
// Optional macro YSYX_22040365_IFU_MISALIGN_CHECK_EN turns misaligned redirects into a flagged NOP.
module ysyx_22040365_ifu
    import ysyx_22040365_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    ifu_state_e        state, state_next;
    logic              kill, kill_next;
    logic              inst_valid_next;
    logic [INST_W-1:0] inst_next;
    logic [ADDR_W-1:0] inst_pc_next;
    logic              inst_err_next;
    logic              pc_advance;
    logic [ADDR_W-1:0] pc;
    logic              misalign;

`ifdef YSYX_22040365_IFU_MISALIGN_CHECK_EN
    assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    ysyx_22040365_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .advance (pc_advance),
        .pc      (pc)
    );

    assign imem_req_addr = pc;

    always_comb begin
        state_next      = state;
        kill_next       = kill;
        inst_valid_next = inst_valid;
        inst_next       = inst;
        inst_pc_next    = inst_pc;
        inst_err_next   = inst_err;
        pc_advance      = 1'b0;
        imem_req_valid  = 1'b0;
        case (state)
            S_REQ: begin
                // kill can only be pending here after a misaligned redirect left a request in flight
                imem_req_valid = ~redirect_valid & ~kill;
                if (!redirect_valid && !kill && imem_req_ready) begin
                    state_next = S_WAIT;
                end
                if (imem_rsp_valid) begin
                    kill_next = 1'b0;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    kill_next  = ~imem_rsp_valid;
                    state_next = imem_rsp_valid ? S_REQ : S_WAIT;
                end else if (imem_rsp_valid) begin
                    kill_next = 1'b0;
                    if (kill) begin
                        state_next = S_REQ;
                    end else begin
                        inst_valid_next = 1'b1;
                        inst_next       = imem_rsp_data;
                        inst_pc_next    = pc;
                        inst_err_next   = 1'b0;
                        state_next      = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (imem_rsp_valid) begin
                    kill_next = 1'b0;
                end
                if (redirect_valid) begin
                    inst_valid_next = 1'b0;
                    state_next      = S_REQ;
                end else if (inst_ready) begin
                    inst_valid_next = 1'b0;
                    pc_advance      = 1'b1;
                    state_next      = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
        if (misalign) begin
            state_next      = S_OUT;
            inst_valid_next = 1'b1;
            inst_next       = NOP_INST;
            inst_pc_next    = redirect_pc;
            inst_err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_REQ;
            kill       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= RESET_PC;
            inst_err   <= 1'b0;
        end else begin
            state      <= state_next;
            kill       <= kill_next;
            inst_valid <= inst_valid_next;
            inst       <= inst_next;
            inst_pc    <= inst_pc_next;
            inst_err   <= inst_err_next;
        end
    end

endmodule
